// File: rtl/align_out_buffer_pkg.sv
// Shared alphabet, symbol encodings and FSM state type for the alignment output path.
// Letters occupy codes 0..2**LETTER_WIDTH-1; LINE and START_END_SIGNAL sit above them.
package design_variables;

  localparam int SEQ_LENGTH   = 8;
  localparam int LETTER_WIDTH = 2;

  typedef logic [LETTER_WIDTH:0] sym_t;

  localparam sym_t LINE             = 3'b100;
  localparam sym_t START_END_SIGNAL = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_t;

endpackage

// File: rtl/align_lifo.sv
// Column-pair stack: push/pop one pair per cycle; top is read combinationally, 0-cycle latency.
// No internal backpressure: the owner must not push when full or pop when empty.
module align_lifo
  import design_variables::*;
#(
  parameter int DEPTH = 2 * SEQ_LENGTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  sym_t             push_q,
  input  sym_t             push_d,
  output logic             full,
  output logic             empty,
  output sym_t             top_q,
  output sym_t             top_d,
  output logic [CNT_W-1:0] ptr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sym_t             mem_q [DEPTH];
  sym_t             mem_d [DEPTH];
  logic [CNT_W-1:0] ptr_m1;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign full   = (ptr == CNT_W'(DEPTH));
  assign empty  = (ptr == '0);
  assign ptr_m1 = ptr - CNT_W'(1);
  assign wr_idx = ptr[IDX_W-1:0];
  assign rd_idx = ptr_m1[IDX_W-1:0];
  assign top_q  = mem_q[rd_idx];
  assign top_d  = mem_d[rd_idx];

  // Storage deliberately has no reset; stale entries are never visible past ptr.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_q;
      mem_d[wr_idx] <= push_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptr_m1;
    end
  end

endmodule

// File: rtl/align_out_buffer.sv
// Reverses traceback column pairs into forward order; first out_valid one cycle after closing marker.
// Input stalls (in_ready=0) for the whole drain; output holds data while out_ready is low. Option: ALIGN_OUT_GAP_COUNT_EN.
module align_out_buffer
  import design_variables::*;
#(
  parameter int DEPTH = 2 * SEQ_LENGTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [LETTER_WIDTH:0]   query_in,
  input  logic [LETTER_WIDTH:0]   database_in,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LETTER_WIDTH:0]   query_out,
  output logic [LETTER_WIDTH:0]   database_out,
  output logic                    out_last,
`ifdef ALIGN_OUT_GAP_COUNT_EN
  output logic [CNT_W-1:0]        query_gaps,
  output logic [CNT_W-1:0]        database_gaps,
`endif
  output logic [CNT_W-1:0]        length,
  output logic                    overflow
);

  state_t           state;
  state_t           state_nxt;
  logic             marker;
  logic             lifo_clr;
  logic             lifo_push;
  logic             lifo_pop;
  logic             set_ovf;
  logic             lifo_full;
  logic             lifo_empty;
  sym_t             top_q;
  sym_t             top_d;
  logic [CNT_W-1:0] ptr;

  assign marker = in_valid && (query_in == START_END_SIGNAL) && (database_in == START_END_SIGNAL);

  align_lifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_lifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (lifo_clr),
    .push   (lifo_push),
    .pop    (lifo_pop),
    .push_q (query_in),
    .push_d (database_in),
    .full   (lifo_full),
    .empty  (lifo_empty),
    .top_q  (top_q),
    .top_d  (top_d),
    .ptr    (ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lifo_clr  = 1'b0;
    lifo_push = 1'b0;
    lifo_pop  = 1'b0;
    set_ovf   = 1'b0;
    unique case (state)
      IDLE: begin
        if (marker) begin
          lifo_clr  = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (marker) begin
          state_nxt = lifo_empty ? IDLE : DRAIN;
        end else if (in_valid) begin
          lifo_push = !lifo_full;
          set_ovf   = lifo_full;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          lifo_pop = 1'b1;
          if (ptr == CNT_W'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data is gated by out_valid so outputs read zero outside DRAIN, independent of storage.
  assign in_ready     = (state != DRAIN);
  assign out_valid    = (state == DRAIN);
  assign out_last     = out_valid && (ptr == CNT_W'(1));
  assign query_out    = out_valid ? top_q : '0;
  assign database_out = out_valid ? top_d : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      length   <= '0;
      overflow <= 1'b0;
    end else if (lifo_clr) begin
      length   <= '0;
      overflow <= 1'b0;
    end else begin
      if (lifo_push) length <= ptr + CNT_W'(1);
      if (set_ovf) overflow <= 1'b1;
    end
  end

`ifdef ALIGN_OUT_GAP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      query_gaps    <= '0;
      database_gaps <= '0;
    end else if (lifo_clr) begin
      query_gaps    <= '0;
      database_gaps <= '0;
    end else if (lifo_push) begin
      if (query_in == LINE) query_gaps <= query_gaps + CNT_W'(1);
      if (database_in == LINE) database_gaps <= database_gaps + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_align_out_buffer.sv
// Scoreboard bench for align_out_buffer: pushed pairs go on a queue, drained output is compared LIFO-order.
module tb_align_out_buffer;
  import design_variables::*;

  localparam int DEPTH = 2 * SEQ_LENGTH;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam sym_t S_A = 3'd0;
  localparam sym_t S_C = 3'd1;
  localparam sym_t S_G = 3'd2;
  localparam sym_t S_T = 3'd3;

  typedef struct packed {
    sym_t q;
    sym_t d;
  } pair_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  sym_t             query_in;
  sym_t             database_in;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  sym_t             query_out;
  sym_t             database_out;
  logic             out_last;
  logic [CNT_W-1:0] length;
  logic             overflow;
`ifdef ALIGN_OUT_GAP_COUNT_EN
  logic [CNT_W-1:0] query_gaps;
  logic [CNT_W-1:0] database_gaps;
`endif

  pair_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  align_out_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .query_in      (query_in),
    .database_in   (database_in),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .query_out     (query_out),
    .database_out  (database_out),
    .out_last      (out_last),
`ifdef ALIGN_OUT_GAP_COUNT_EN
    .query_gaps    (query_gaps),
    .database_gaps (database_gaps),
`endif
    .length        (length),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input sym_t q, input sym_t d);
    in_valid    = 1'b1;
    query_in    = q;
    database_in = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_marker();
    send(START_END_SIGNAL, START_END_SIGNAL);
  endtask

  // Model: only the first DEPTH pairs of an alignment are retained.
  task automatic push_pair(input sym_t q, input sym_t d);
    pair_t p;
    send(q, d);
    p.q = q;
    p.d = d;
    if (exp_q.size() < DEPTH) exp_q.push_back(p);
  endtask

  task automatic drain(input bit stall, input int n);
    bit [0:4] pat;
    int       pops;
    int       cyc;
    pair_t    e;
    pat  = 5'b10011;
    pops = 0;
    cyc  = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      out_ready = stall ? pat[cyc % 5] : 1'b1;
      #1;
      e = exp_q[$];
      checks++;
      if (out_valid !== 1'b1 || query_out !== e.q || database_out !== e.d) begin
        errors++;
        $display("FAIL drain_data cyc=%0d: got v=%b q=%h d=%h, want v=1 q=%h d=%h",
                 cyc, out_valid, query_out, database_out, e.q, e.d);
      end
      checks++;
      if (out_last !== (exp_q.size() == 1)) begin
        errors++;
        $display("FAIL drain_last cyc=%0d: got %b, want %b", cyc, out_last, exp_q.size() == 1);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL drain_in_ready cyc=%0d: got %b, want 0", cyc, in_ready);
      end
      if (out_valid === 1'b1 && out_ready) begin
        void'(exp_q.pop_back());
        pops++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (pops != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_count: got %0d pops (%0d left), want %0d", pops, exp_q.size(), n);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL drain_idle: got v=%b rdy=%b state=%0d, want v=0 rdy=1 state=IDLE",
               out_valid, in_ready, dut.state);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    query_in    = '0;
    database_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 ||
        query_out !== '0 || database_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b last=%b rdy=%b q=%h d=%h, want 0 0 1 0 0",
               out_valid, out_last, in_ready, query_out, database_out);
    end
    checks++;
    if (length !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got len=%0d ovf=%b, want 0 0", length, overflow);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    send_marker();
    push_pair(S_A, S_A);
    push_pair(S_C, LINE);
    push_pair(S_G, S_T);
    send_marker();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_first_valid: got %b, want 1", out_valid);
    end
    checks++;
    if (length !== CNT_W'(3)) begin
      errors++;
      $display("FAIL basic_length: got %0d, want 3", length);
    end
    drain(1'b0, 3);
  endtask

  task automatic test_empty();
    send_marker();
    checks++;
    if (length !== '0) begin
      errors++;
      $display("FAIL empty_len_clear: got %0d, want 0", length);
    end
    send_marker();
    repeat (2) begin
      checks++;
      if (out_valid !== 1'b0 || dut.state !== IDLE) begin
        errors++;
        $display("FAIL empty_idle: got v=%b state=%0d, want v=0 state=IDLE", out_valid, dut.state);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    send_marker();
    push_pair(S_T, S_G);
    push_pair(LINE, S_C);
    push_pair(S_A, S_T);
    send_marker();
    drain(1'b1, 3);
  endtask

  task automatic test_overflow();
    send_marker();
    for (int i = 0; i < DEPTH + 2; i++) push_pair(sym_t'(i % 4), sym_t'((i + 1) % 4));
    send_marker();
    checks++;
    if (overflow !== 1'b1 || length !== CNT_W'(DEPTH)) begin
      errors++;
      $display("FAIL overflow_flag: got ovf=%b len=%0d, want 1 %0d", overflow, length, DEPTH);
    end
    drain(1'b0, DEPTH);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b, want 1", overflow);
    end
  endtask

  task automatic test_reset_mid_drain();
    send_marker();
    push_pair(S_A, S_C);
    push_pair(S_C, S_G);
    push_pair(S_G, S_T);
    push_pair(S_T, S_A);
    send_marker();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    void'(exp_q.pop_back());
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || length !== '0 || overflow !== 1'b0 || in_ready !== 1'b1 ||
        query_out !== '0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b len=%0d ovf=%b rdy=%b q=%h, want 0 0 0 1 0",
               out_valid, length, overflow, in_ready, query_out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    send_marker();
    push_pair(S_G, S_G);
    push_pair(S_C, S_A);
    send_marker();
    checks++;
    if (length !== CNT_W'(2)) begin
      errors++;
      $display("FAIL reset_next_len: got %0d, want 2", length);
    end
    drain(1'b0, 2);
  endtask

`ifdef ALIGN_OUT_GAP_COUNT_EN
  task automatic test_gaps();
    send_marker();
    push_pair(LINE, S_A);
    push_pair(S_C, LINE);
    push_pair(S_T, LINE);
    send_marker();
    checks++;
    if (query_gaps !== CNT_W'(1) || database_gaps !== CNT_W'(2)) begin
      errors++;
      $display("FAIL gaps: got q=%0d d=%0d, want 1 2", query_gaps, database_gaps);
    end
    drain(1'b0, 3);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_stall();
    test_overflow();
    test_reset_mid_drain();
`ifdef ALIGN_OUT_GAP_COUNT_EN
    test_gaps();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/align_out_buffer.md
ALIGN_OUT_BUFFER -- requirements
Module: align_out_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2*SEQ_LENGTH, maximum number of stored alignment column pairs.
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH+1), width of the occupancy counter.
REQ-003 SHALL have clk  input  1  clock, rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have in_valid  input  1  the traceback stage presents a column pair this cycle.
REQ-006 SHALL have query_in  input  LETTER_WIDTH+1  query letter, LINE or START_END_SIGNAL.
REQ-007 SHALL have database_in  input  LETTER_WIDTH+1  database letter, LINE or START_END_SIGNAL.
REQ-008 SHALL have in_ready  output  1  high when not in DRAIN.
REQ-009 SHALL have out_valid  output  1  forward-order pair available.
REQ-010 SHALL have out_ready  input  1  consumer accepts the pair.
REQ-011 SHALL have query_out, database_out  output  LETTER_WIDTH+1 each  forward-order pair.
REQ-012 SHALL have out_last  output  1  marks the final pair of an alignment.
REQ-013 SHALL have length  output  CNT_W  pair count of the current or last alignment.
REQ-014 SHALL have overflow  output  1  sticky flag for a push attempted while full.

Function
REQ-015 SHALL use states IDLE, COLLECT and DRAIN.
REQ-016 SHALL define a marker as in_valid with both inputs equal to START_END_SIGNAL.
REQ-017 SHALL, in IDLE, on a marker, clear the pointer, length and overflow and go to COLLECT; other input SHALL be ignored.
REQ-018 SHALL, in COLLECT, push each non-marker pair onto the LIFO, increment the pointer and set length to the pointer plus one.
REQ-019 SHALL, in COLLECT, on a marker, go to DRAIN if the pointer is nonzero and to IDLE if it is zero; the marker SHALL NOT be stored.
REQ-020 SHALL, on a push with pointer==DEPTH, drop the pair, set overflow and leave the pointer unchanged.
REQ-021 SHALL, in DRAIN, drive out_valid=1 and out data = LIFO[pointer-1] combinationally from storage.
REQ-022 SHALL pop on out_valid&&out_ready; data SHALL be held stable while out_ready is low.
REQ-023 SHALL assert out_last when pointer==1 in DRAIN; popping it SHALL return the block to IDLE.
REQ-024 SHALL produce first out_valid the cycle after the closing marker is sampled; throughput SHALL be one pair per cycle.
REQ-025 SHALL keep in_ready=0 in DRAIN and ignore in_valid there; length SHALL hold until the next opening marker.

Reset
REQ-026 SHALL, on rst_n low, at any time including mid-COLLECT or mid-DRAIN, go to IDLE with pointer=0, length=0 and overflow=0.
REQ-027 SHALL reset outputs to out_valid=0, out_last=0, in_ready=1, query_out=0 and database_out=0; storage contents SHALL NOT be reset.

Configuration
REQ-028 SHALL, with ALIGN_OUT_GAP_COUNT_EN defined, add outputs query_gaps and database_gaps (CNT_W each), counting LINE entries pushed per alignment, cleared with length.
REQ-029 SHALL, without ALIGN_OUT_GAP_COUNT_EN, omit both ports and counters with no other behavioural change.

Structure
REQ-030 SHALL take SEQ_LENGTH, LETTER_WIDTH, LINE, START_END_SIGNAL and the state enum typedef from package design_variables.
REQ-031 SHALL place storage and pointer in sub-module align_lifo (push, pop, full, empty, top); the FSM, length and flags stay in the top.

Verification
REQ-032 SHALL cover: marker, pairs (A,A),(C,LINE),(G,T), marker, out_ready=1 -> outputs (G,T),(C,LINE),(A,A); out_last on the third; length=3.
REQ-033 SHALL cover: marker, marker -> no out_valid; state back to IDLE; length=0.
REQ-034 SHALL cover: a 3-pair drain with out_ready toggled 1,0,0,1,1 -> data held across stalls; exactly 3 pops; out_last only on the last.
REQ-035 SHALL cover: DEPTH+2 pairs then marker -> overflow=1; exactly DEPTH pairs drained, in reverse order.
REQ-036 SHALL cover: rst_n pulse during DRAIN after 1 of 4 pops -> out_valid=0, length=0; the next alignment drains correctly.
REQ-037 SHALL cover, with ALIGN_OUT_GAP_COUNT_EN: pairs (LINE,A),(C,LINE),(T,LINE) -> query_gaps=1, database_gaps=2.
